// File: rtl/bcd_serial_addsub.sv
// Digit-serial signed BCD adder/subtractor.
// One BCD digit is processed per clock through a single 4-bit add with +6
// correction. Subtraction adds the 9's complement of b with carry-in 1; a
// negative difference is turned into its magnitude by a second pass
// (NEGFIX) that forms the 10's complement of the partial result.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry,
  output logic                neg,
  output logic                invalid
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    NEGFIX = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [4*DIGITS-1:0] a_q, b_q;
  logic                sub_q;
  logic [IW-1:0]       idx;
  logic                c;

  logic                in_bad;
  logic                last;
  logic [3:0]          a_dig, b_dig, r_dig;
  logic [3:0]          op_x, op_y;
  logic [4:0]          s5;
  logic [3:0]          digit;
  logic                c_next;
  logic [4*DIGITS-1:0] result_upd;

  assign last  = (idx == LAST_IDX);
  assign a_dig = 4'(a_q >> {idx, 2'b00});
  assign b_dig = 4'(b_q >> {idx, 2'b00});
  assign r_dig = 4'(result >> {idx, 2'b00});

  // Flag any non-BCD digit on the live inputs so it can be latched at accept
  always_comb begin
    in_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // Shared digit adder: RUN adds a[i] and (9's complement of) b[i]; NEGFIX
  // adds the 9's complement of the stored digit to the running carry
  always_comb begin
    op_x = a_dig;
    op_y = sub_q ? (4'd9 - b_dig) : b_dig;
    if (state == NEGFIX) begin
      op_x = 4'd9 - r_dig;
      op_y = 4'd0;
    end
    s5 = {1'b0, op_x} + {1'b0, op_y} + {4'd0, c};
    if (s5 > 5'd9) begin
      digit  = 4'(s5 + 5'd6);
      c_next = 1'b1;
    end else begin
      digit  = s5[3:0];
      c_next = 1'b0;
    end
  end

  // Result with the current digit position replaced by the new digit
  always_comb begin
    result_upd = result;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) result_upd[4*k +: 4] = digit;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = in_bad ? DONE : RUN;
      RUN:     if (last) state_next = (sub_q && !c_next) ? NEGFIX : DONE;
      NEGFIX:  if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latches, digit counter, result build-up and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx     <= '0;
      c       <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      neg     <= 1'b0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            idx     <= '0;
            c       <= sub;
            result  <= '0;
            carry   <= 1'b0;
            neg     <= 1'b0;
            invalid <= in_bad;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          result <= result_upd;
          c      <= c_next;
          idx    <= last ? '0 : idx + 1'b1;
          if (last) begin
            if (!sub_q) begin
              carry <= c_next;
            end else if (!c_next) begin
              neg <= 1'b1;
              c   <= 1'b1;
            end
          end
        end
        NEGFIX: begin
          result <= result_upd;
          c      <= c_next;
          idx    <= last ? '0 : idx + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Testbench for bcd_serial_addsub: directed vector table on a 4-digit
// instance, hand-written corner sequences, and a full sweep of a 1-digit
// instance against a behavioural model.
module tb_bcd_serial_addsub;

  logic clk;
  logic rst_n;

  logic        start4, sub4;
  logic [15:0] a4, b4;
  logic        busy4, done4, carry4, neg4, invalid4;
  logic [15:0] result4;

  logic        start1, sub1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, carry1, neg1, invalid1;
  logic [3:0]  result1;

  int total;
  int bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_result;
    logic        exp_carry;
    logic        exp_neg;
    logic        exp_invalid;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4),
    .neg(neg4), .invalid(invalid4)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1),
    .neg(neg1), .invalid(invalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one op on the 4-digit DUT and return cycles from E0 to done
  task automatic applyStimulus(input logic [15:0] a_in, input logic [15:0] b_in,
                               input logic sub_in, output int lat);
    @(negedge clk);
    a4 = a_in; b4 = b_in; sub4 = sub_in; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = ~a_in; b4 = ~b_in; sub4 = ~sub_in;
    lat = 0;
    while (lat < 40 && !done4) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Launch one op on the 1-digit DUT
  task automatic run1(input logic [3:0] a_in, input logic [3:0] b_in,
                      input logic sub_in, output int lat);
    @(negedge clk);
    a1 = a_in; b1 = b_in; sub1 = sub_in; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    lat = 0;
    while (lat < 40 && !done1) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dcount;
    int dlat;
    logic [15:0] held;
    total = 0;
    bad = 0;
    start4 = 0; sub4 = 0; a4 = '0; b4 = '0;
    start1 = 0; sub1 = 0; a1 = '0; b1 = '0;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5};
    vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
    vecs[2]  = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b0, 5};
    vecs[3]  = '{16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{16'h1234, 16'h5000, 1'b1, 16'h3766, 1'b0, 1'b1, 1'b0, 9};
    vecs[5]  = '{16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 9};
    vecs[6]  = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[8]  = '{16'h9999, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 5};
    vecs[9]  = '{16'h0000, 16'h9999, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 9};
    vecs[10] = '{16'h0000, 16'h00B0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5};

    // Reset state
    rst_n = 1'b0;
    #3;
    checkOutput("reset_busy", {31'd0, busy4}, 32'd0);
    checkOutput("reset_done", {31'd0, done4}, 32'd0);
    checkOutput("reset_result", {16'd0, result4}, 32'd0);
    checkOutput("reset_flags", {29'd0, carry4, neg4, invalid4}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_result", i), {16'd0, result4}, {16'd0, vecs[i].exp_result});
      checkOutput($sformatf("v%0d_carry", i), {31'd0, carry4}, {31'd0, vecs[i].exp_carry});
      checkOutput($sformatf("v%0d_neg", i), {31'd0, neg4}, {31'd0, vecs[i].exp_neg});
      checkOutput($sformatf("v%0d_invalid", i), {31'd0, invalid4}, {31'd0, vecs[i].exp_invalid});
      checkOutput($sformatf("v%0d_busy_at_done", i), {31'd0, busy4}, 32'd0);
    end

    // Results hold after done until the next accept
    held = result4;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("hold_result", {16'd0, result4}, {16'd0, held});
    checkOutput("hold_done_low", {31'd0, done4}, 32'd0);

    // Start pulses while busy are ignored: exactly one done
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    dcount = 0;
    dlat = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        dcount++;
        dlat = k;
      end
      if (k == 1) start4 = 1'b1;
      if (k == 3) start4 = 1'b0;
    end
    checkOutput("ignored_start_dones", dcount, 1);
    checkOutput("ignored_start_latency", dlat, 5);
    checkOutput("ignored_start_result", {16'd0, result4}, 32'h6912);

    // Asynchronous reset mid-operation aborts without a done pulse
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy4}, 32'd0);
    checkOutput("abort_result", {16'd0, result4}, 32'd0);
    checkOutput("abort_flags", {28'd0, done4, carry4, neg4, invalid4}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done4) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done4) dcount++;
    end
    checkOutput("abort_no_done", dcount, 0);
    applyStimulus(16'h1234, 16'h5678, 1'b0, lat);
    checkOutput("after_abort_latency", lat, 5);
    checkOutput("after_abort_result", {16'd0, result4}, 32'h6912);

    // Exhaustive single-digit sweep against a behavioural model
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        for (int s = 0; s < 2; s++) begin
          int d, m_res, m_carry, m_neg, m_lat;
          if (s == 1) begin
            d = x - y;
            m_neg = (d < 0) ? 1 : 0;
            m_res = (d < 0) ? -d : d;
            m_carry = 0;
          end else begin
            d = x + y;
            m_neg = 0;
            m_res = d % 10;
            m_carry = (d >= 10) ? 1 : 0;
          end
          m_lat = m_neg ? 3 : 2;
          run1(4'(x), 4'(y), s[0], lat);
          checkOutput($sformatf("d1_%0d_%0d_%0d_lat", x, y, s), lat, m_lat);
          checkOutput($sformatf("d1_%0d_%0d_%0d_res", x, y, s), {28'd0, result1}, m_res);
          checkOutput($sformatf("d1_%0d_%0d_%0d_flags", x, y, s),
                      {29'd0, carry1, neg1, invalid1}, (m_carry << 2) | (m_neg << 1));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
